// File: rtl/cpu16_pkg.sv
// Shared definitions for the 16-bit multi-cycle CPU control path:
// opcode map, ALU/mux encodings, sequencer states and instruction classes.
package cpu16_pkg;

  localparam logic [3:0] OP_RLOGIC = 4'b0000;
  localparam logic [3:0] OP_RARITH = 4'b0001;
  localparam logic [3:0] OP_SHIFT  = 4'b0010;
  localparam logic [3:0] OP_ADDI   = 4'b1001;
  localparam logic [3:0] OP_SUBI   = 4'b1010;
  localparam logic [3:0] OP_SLTI   = 4'b1011;
  localparam logic [3:0] OP_LW     = 4'b1100;
  localparam logic [3:0] OP_SW     = 4'b1101;
  localparam logic [3:0] OP_BEQ    = 4'b1111;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_IMM   = 2'b11;

  localparam logic [1:0] ALUSRCB_REG     = 2'b00;
  localparam logic [1:0] ALUSRCB_CONST2  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH1 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_ALU,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_MEM,
    S_BRANCH
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LW,
    CLS_SW,
    CLS_BEQ,
    CLS_ILL
  } class_e;

  // Map a raw opcode onto its instruction class.
  function automatic class_e decode_class(input logic [3:0] op);
    class_e cls;
    case (op)
      OP_RLOGIC, OP_RARITH, OP_SHIFT: cls = CLS_R;
      OP_ADDI, OP_SUBI, OP_SLTI:      cls = CLS_I;
      OP_LW:                          cls = CLS_LW;
      OP_SW:                          cls = CLS_SW;
      OP_BEQ:                         cls = CLS_BEQ;
      default:                        cls = CLS_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/multicycle_output_decode.sv
// Moore output decode for the multi-cycle sequencer. Only ir_write/pc_write
// in FETCH see mem_ready, only pc_write_cond sees zero, and only illegal sees
// the live opcode class.
module multicycle_output_decode
  import cpu16_pkg::*;
(
  input  logic       reset,
  input  state_e     state,
  input  class_e     cls,
  input  logic       illegal_op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal
);

  // Per-state control word; everything is held low while reset is asserted
  // so an in-flight memory request is dropped in the same cycle.
  always_comb begin
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALUSRCB_REG;
    alu_op        = ALU_OP_ADD;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal       = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = ALUSRCB_CONST2;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = ALUSRCB_IMM_SH1;
          illegal   = illegal_op;
        end
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_OP_FUNCT;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUSRCB_IMM;
          alu_op    = ALU_OP_IMM;
        end
        S_WB_ALU: begin
          reg_write = 1'b1;
          reg_dst   = (cls == CLS_R);
        end
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = ALUSRCB_IMM;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WR: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_WB_MEM: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_OP_SUB;
          pc_src        = 1'b1;
          pc_write_cond = zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle sequencer for the 16-bit CPU: state register, latched
// instruction class and retired-instruction counter.
//
// state      | meaning
// S_FETCH    | read instruction at PC, wait for mem_ready, PC += 2
// S_DECODE   | branch target into ALUOut, latch class, flag illegal
// S_EXEC_R   | R-type ALU operation on A, B
// S_EXEC_I   | immediate ALU operation on A, imm
// S_WB_ALU   | write ALUOut to rd (R) or rt (I); retire
// S_MEM_ADDR | effective address A + imm
// S_MEM_RD   | data read at ALUOut, wait for mem_ready
// S_MEM_WR   | data write at ALUOut, wait for mem_ready; retire
// S_WB_MEM   | write MDR to rt; retire
// S_BRANCH   | compare A, B; PC <= ALUOut when zero; retire
module multicycle_control_fsm
  import cpu16_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  logic [CNT_W-1:0] count_q, count_d;
  class_e           class_live;
  logic             retire;

  assign class_live  = decode_class(opcode);
  assign instr_count = count_q;

  // Next state, class latch and retire strobe.
  always_comb begin
    state_d = state_q;
    class_d = class_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        class_d = class_live;
        case (class_live)
          CLS_R:          state_d = S_EXEC_R;
          CLS_I:          state_d = S_EXEC_I;
          CLS_LW, CLS_SW: state_d = S_MEM_ADDR;
          CLS_BEQ:        state_d = S_BRANCH;
          default:        state_d = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
      S_MEM_ADDR: state_d = (class_q == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (mem_ready) state_d = S_WB_MEM;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_WB_ALU, S_WB_MEM, S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
    count_d = count_q + {{(CNT_W-1){1'b0}}, retire};
  end

  // State, class and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      class_q <= CLS_R;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      count_q <= count_d;
    end
  end

  multicycle_output_decode u_output_decode (
    .reset         (reset),
    .state         (state_q),
    .cls           (class_q),
    .illegal_op    (class_live == CLS_ILL),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .illegal       (illegal)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm. A 16-bit-counter instance
// and an 8-bit-counter instance share stimulus; the narrow one makes counter
// wrap reachable in a short run.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] opcode = 4'b0000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond;
  logic        pc_src, alu_src_a, reg_dst, mem_to_reg, reg_write, illegal;
  logic [1:0]  alu_src_b, alu_op;
  logic [15:0] instr_count;

  logic        s_mem_read, s_mem_write, s_i_or_d, s_ir_write, s_pc_write, s_pc_write_cond;
  logic        s_pc_src, s_alu_src_a, s_reg_dst, s_mem_to_reg, s_reg_write, s_illegal;
  logic [1:0]  s_alu_src_b, s_alu_op;
  logic [7:0]  s_instr_count;

  int vectors = 0;
  int miscompares = 0;
  int model_cnt16 = 0;
  int model_cnt8 = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .illegal(illegal),
    .instr_count(instr_count)
  );

  multicycle_control_fsm #(.CNT_W(8)) dut_small (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(s_mem_read), .mem_write(s_mem_write), .i_or_d(s_i_or_d),
    .ir_write(s_ir_write), .pc_write(s_pc_write), .pc_write_cond(s_pc_write_cond),
    .pc_src(s_pc_src), .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b),
    .alu_op(s_alu_op), .reg_dst(s_reg_dst), .mem_to_reg(s_mem_to_reg),
    .reg_write(s_reg_write), .illegal(s_illegal), .instr_count(s_instr_count)
  );

  logic [15:0] ctrl, s_ctrl;
  assign ctrl = {mem_read, mem_write, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
                 alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg, reg_write, illegal};
  assign s_ctrl = {s_mem_read, s_mem_write, s_i_or_d, s_ir_write, s_pc_write, s_pc_write_cond,
                   s_pc_src, s_alu_src_a, s_alu_src_b, s_alu_op, s_reg_dst, s_mem_to_reg,
                   s_reg_write, s_illegal};

  typedef enum int {P_RESET, P_FETCH, P_DECODE, P_DEC_ILL, P_EXEC_R, P_EXEC_I, P_WB_ALU,
                    P_MEM_ADDR, P_MEM_RD, P_MEM_WR, P_WB_MEM, P_BRANCH} phase_e;
  typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_ILL} kind_e;
  typedef struct { phase_e p; bit rdy; } step_t;

  function automatic kind_e kind_of(input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010: return K_R;
      4'b1001, 4'b1010, 4'b1011: return K_I;
      4'b1100: return K_LW;
      4'b1101: return K_SW;
      4'b1111: return K_BEQ;
      default: return K_ILL;
    endcase
  endfunction

  // Control word the spec table gives for one cycle of a phase.
  function automatic logic [15:0] exp_ctrl(input phase_e p, input bit rdy, input bit z,
                                           input bit was_r);
    logic mr, mw, iod, irw, pcw, pcwc, pcs, asa, rdst, m2r, rw, ill;
    logic [1:0] asb, aop;
    {mr, mw, iod, irw, pcw, pcwc, pcs, asa, rdst, m2r, rw, ill} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (p)
      P_FETCH:    begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      P_DECODE:   asb = 2'b11;
      P_DEC_ILL:  begin asb = 2'b11; ill = 1; end
      P_EXEC_R:   begin asa = 1; asb = 2'b00; aop = 2'b10; end
      P_EXEC_I:   begin asa = 1; asb = 2'b10; aop = 2'b11; end
      P_WB_ALU:   begin rw = 1; rdst = was_r; end
      P_MEM_ADDR: begin asa = 1; asb = 2'b10; end
      P_MEM_RD:   begin mr = 1; iod = 1; end
      P_MEM_WR:   begin mw = 1; iod = 1; end
      P_WB_MEM:   begin rw = 1; m2r = 1; end
      P_BRANCH:   begin asa = 1; aop = 2'b01; pcs = 1; pcwc = z; end
      default: ;
    endcase
    return {mr, mw, iod, irw, pcw, pcwc, pcs, asa, asb, aop, rdst, m2r, rw, ill};
  endfunction

  // Drive one instruction: fw fetch waits, mw data waits, branch zero z.
  // Opcode is scrambled after DECODE so later states must use the latched class.
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input bit z);
    step_t q[$];
    kind_e k = kind_of(op);
    int dec_idx;
    logic [15:0] exp;
    for (int i = 0; i < fw; i++) q.push_back('{P_FETCH, 1'b0});
    q.push_back('{P_FETCH, 1'b1});
    dec_idx = q.size();
    q.push_back('{(k == K_ILL) ? P_DEC_ILL : P_DECODE, 1'b0});
    case (k)
      K_R:   begin q.push_back('{P_EXEC_R, 1'b0}); q.push_back('{P_WB_ALU, 1'b0}); end
      K_I:   begin q.push_back('{P_EXEC_I, 1'b0}); q.push_back('{P_WB_ALU, 1'b0}); end
      K_LW: begin
        q.push_back('{P_MEM_ADDR, 1'b0});
        for (int i = 0; i < mw; i++) q.push_back('{P_MEM_RD, 1'b0});
        q.push_back('{P_MEM_RD, 1'b1});
        q.push_back('{P_WB_MEM, 1'b0});
      end
      K_SW: begin
        q.push_back('{P_MEM_ADDR, 1'b0});
        for (int i = 0; i < mw; i++) q.push_back('{P_MEM_WR, 1'b0});
        q.push_back('{P_MEM_WR, 1'b1});
      end
      K_BEQ: q.push_back('{P_BRANCH, 1'b0});
      default: ;
    endcase
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].p inside {P_FETCH, P_MEM_RD, P_MEM_WR}) mem_ready = q[i].rdy;
      else mem_ready = 1'($urandom);
      zero   = (q[i].p == P_BRANCH) ? z : 1'($urandom);
      opcode = (i <= dec_idx) ? op : 4'($urandom);
      @(negedge clk);
      exp = exp_ctrl(q[i].p, q[i].rdy, z, k == K_R);
      vectors++;
      if (ctrl !== exp || s_ctrl !== exp) begin
        miscompares++;
        $display("FAIL ctrl op=%b step=%0d phase=%s got=%b small=%b exp=%b",
                 op, i, q[i].p.name(), ctrl, s_ctrl, exp);
      end
      @(posedge clk); #1;
    end
    if (k != K_ILL) begin
      model_cnt16 = (model_cnt16 + 1) % 65536;
      model_cnt8  = (model_cnt8 + 1) % 256;
    end
    vectors++;
    if (instr_count !== 16'(model_cnt16) || s_instr_count !== 8'(model_cnt8)) begin
      miscompares++;
      $display("FAIL instr_count op=%b got=%h/%h exp=%h/%h",
               op, instr_count, s_instr_count, 16'(model_cnt16), 8'(model_cnt8));
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (ctrl !== 16'h0 || s_ctrl !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_outputs cycle=%0d got=%b exp=0", c, ctrl);
      end
      @(posedge clk); #1;
    end
    model_cnt16 = 0;
    model_cnt8 = 0;
    vectors++;
    if (instr_count !== 16'h0 || s_instr_count !== 8'h0) begin
      miscompares++;
      $display("FAIL reset_count got=%h exp=0000", instr_count);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (ctrl !== exp_ctrl(P_FETCH, 1'b1, 1'b0, 1'b0)) begin
      miscompares++;
      $display("FAIL first_fetch got=%b exp=%b", ctrl, exp_ctrl(P_FETCH, 1'b1, 1'b0, 1'b0));
    end
    @(posedge clk); #1;
    // Finish the instruction just fetched (R-type add) so the model stays aligned.
    opcode = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    model_cnt16++;
    model_cnt8++;
  endtask

  task automatic test_r_type();
    run_instr(4'b0001, 0, 0, 1'b0);
    run_instr(4'b0000, 1, 0, 1'b0);
    run_instr(4'b1001, 0, 0, 1'b0);
    run_instr(4'b1011, 2, 0, 1'b1);
  endtask

  task automatic test_lw_wait();
    run_instr(4'b1100, 0, 2, 1'b0);
    run_instr(4'b1100, 0, 0, 1'b0);
    run_instr(4'b1101, 1, 1, 1'b0);
  endtask

  task automatic test_beq();
    run_instr(4'b1111, 0, 0, 1'b1);
    run_instr(4'b1111, 0, 0, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr(4'b0101, 0, 0, 1'b0);
    run_instr(4'b1110, 0, 0, 1'b0);
    run_instr(4'b0011, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 150; n++)
      run_instr(4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom));
  endtask

  task automatic test_wrap();
    int todo = 256 - model_cnt8;
    for (int n = 0; n < todo; n++) run_instr(4'b1101, 0, 0, 1'b0);
    vectors++;
    if (s_instr_count !== 8'h00) begin
      miscompares++;
      $display("FAIL wrap got=%h exp=00", s_instr_count);
    end
  endtask

  task automatic test_reset_mid_memwr();
    mem_ready = 1'b1; opcode = 4'b1101;
    @(posedge clk); #1;                      // FETCH
    mem_ready = 1'b0;
    @(posedge clk); #1;                      // DECODE
    @(posedge clk); #1;                      // MEM_ADDR -> MEM_WR
    @(negedge clk);
    vectors++;
    if (mem_write !== 1'b1) begin
      miscompares++;
      $display("FAIL memwr_before_reset got=%b exp=1", mem_write);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (mem_write !== 1'b0 || ctrl !== 16'h0) begin
      miscompares++;
      $display("FAIL memwr_abort got=%b exp=0 ctrl=%b", mem_write, ctrl);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    model_cnt16 = 0;
    model_cnt8 = 0;
    vectors++;
    if (instr_count !== 16'h0 || s_instr_count !== 8'h0) begin
      miscompares++;
      $display("FAIL abort_count got=%h exp=0000", instr_count);
    end
    run_instr(4'b1001, 0, 0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_random();
    test_wrap();
    test_reset_mid_memwr();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle sequencer for the 16-bit CPU datapath.
- Replaces single-cycle control decode with a Moore FSM that drives the shared datapath through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over several cycles.
- A single unified memory port serves both instruction fetch and data access, with a ready handshake.
- Sits between the instruction register opcode field and every datapath mux/enable; also counts retired instructions.

## Interface
Parameters:
- CNT_W, 16: width of retired-instruction counter.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- opcode  in  4  IR[15:12]; valid from DECODE onward.
- zero  in  1  ALU zero flag; sampled in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load IR from memory data.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load when zero = 1 (already ANDed internally; see BRANCH).
- pc_src  out  1  PC input: 0 = ALU result, 1 = ALUOut.
- alu_src_a  out  1  0 = PC, 1 = reg A.
- alu_src_b  out  2  00 = reg B, 01 = constant 2, 10 = sign-extended immediate, 11 = sign-extended immediate << 1.
- alu_op  out  2  00 = add, 01 = sub, 10 = R-type function field, 11 = immediate op from opcode.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut.
- reg_write  out  1  register file write enable.
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode.
- instr_count  out  CNT_W  retired instructions; wraps modulo 2^CNT_W.

## Operation
Opcode classes:
- R: 0000 (logic), 0001 (add/sub), 0010 (shift).
- I-ALU: 1001 addi, 1010 subi, 1011 slti.
- 1100 lw, 1101 sw, 1111 beq.
- All other opcodes are illegal.

States and outputs (any output not listed is 0):
- FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00.
  - If mem_ready=1: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - R → EXEC_R.
  - I-ALU → EXEC_I.
  - lw/sw → MEM_ADDR.
  - beq → BRANCH.
  - Illegal → illegal=1, go to FETCH, no retire.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_op=10 → WB_ALU.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=11 → WB_ALU.
- WB_ALU: reg_write=1, mem_to_reg=0, reg_dst = 1 for R-type, 0 for I-ALU (from latched class) → FETCH, retire.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00 → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_read=1, i_or_d=1. Stay until mem_ready=1, then go to WB_MEM.
- MEM_WR: mem_write=1, i_or_d=1. Stay until mem_ready=1, then go to FETCH and retire.
- WB_MEM: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH, retire.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write_cond=zero → FETCH, retire.

Opcode handling:
- Opcode class is latched at DECODE.
- Later states use the latched class, not live opcode.

Retire:
- instr_count increments by 1 on the clock edge leaving the final state of each legal instruction.
- 0xFFFF → 0x0000 at CNT_W=16.

## Timing
Reset (synchronous, active-high):
- Next edge: state ← FETCH, instr_count ← 0, latched class ← R.
- While reset=1, all outputs are forced to 0, including mem_read, mem_write, illegal, ir_write, pc_write and reg_write.

Latency, assuming zero wait (mem_ready high in the request cycle):
- R / I-ALU: 4 cycles.
- lw: 5 cycles.
- sw: 4 cycles.
- beq: 3 cycles.
- illegal: 2 cycles.
- Each wait cycle adds 1.

Handshake:
- A request is held constant (mem_read or mem_write, i_or_d) until the cycle where mem_ready=1.
- The access completes in that same cycle.
- mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.

Reset during a memory wait: the request drops combinationally in the same cycle. The memory must tolerate an aborted access.

All outputs are Moore functions of state (plus the zero gate in BRANCH and the opcode gate for illegal). There are no combinational paths from mem_ready to outputs, except the ir_write/pc_write gating in FETCH.

## Structure
- Shared package cpu16_pkg holds:
  - opcode constants (OP_RLOGIC, OP_RARITH, OP_SHIFT, OP_ADDI, OP_SUBI, OP_SLTI, OP_LW, OP_SW, OP_BEQ);
  - the ALU_OP_* and ALUSRCB_* encodings;
  - the state enum.
- One sub-module, multicycle_output_decode: combinational state (+class, zero, mem_ready) → control outputs.
- The top level holds the state register, class latch and counter.

## Test plan
- Reset held 3 cycles, then released with mem_ready=1 → all outputs 0 during reset; FETCH with mem_read=1 on the first cycle after release; instr_count=0.
- opcode=0001, mem_ready=1 → state sequence FETCH, DECODE, EXEC_R, WB_ALU; reg_write=1 and reg_dst=1 only in cycle 4; instr_count 0→1.
- lw (1100) with mem_ready low for 2 cycles in MEM_RD → mem_read and i_or_d=1 held 3 cycles; WB_MEM has mem_to_reg=1; 7 cycles total.
- beq (1111) with zero=1, then zero=0 → pc_write_cond=1 with pc_src=1 in cycle 3, then pc_write_cond=0; each instruction is 3 cycles.
- opcode=0101 → illegal pulses 1 cycle in DECODE, no reg_write or mem_write, back to FETCH, instr_count unchanged.
- Preload-free wrap: run 65536 sw at zero wait → instr_count returns to 0x0000; reset asserted mid-MEM_WR → mem_write drops in the same cycle.
